// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - game datapath signals between the round controller and its environment
interface game_sequencer_if;
    logic        frame_i;
    logic        start_i;
    logic        player_hit_i;
    logic        player_alive_i;
    logic        enemy_killed_i;
    logic        all_enemies_dead_i;
    logic        game_frame_o;
    logic        freeze_o;
    logic        enemy_reset_o;
    logic        add_life_o;
    logic [3:0]  level_o;
    logic [15:0] score_o;
    logic [15:0] high_score_o;
    logic [2:0]  state_o;

    modport master (
        output frame_i, start_i, player_hit_i, player_alive_i, enemy_killed_i, all_enemies_dead_i,
        input  game_frame_o, freeze_o, enemy_reset_o, add_life_o, level_o, score_o, high_score_o, state_o
    );

    modport slave (
        input  frame_i, start_i, player_hit_i, player_alive_i, enemy_killed_i, all_enemies_dead_i,
        output game_frame_o, freeze_o, enemy_reset_o, add_life_o, level_o, score_o, high_score_o, state_o
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round controller: phases, frame gating, level and score; high score under GAME_SEQ_HIGH_SCORE_EN
module game_sequencer #(
    parameter int max_level_p   = 8,
    parameter int points_p      = 10,
    parameter int clear_delay_p = 60
) (
    input  logic clk_i,
    input  logic reset_i,
    game_sequencer_if.slave gs
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  timer_q, timer_d;
    logic        enemy_reset_q, enemy_reset_d;
    logic        add_life_q, add_life_d;
    logic [16:0] award;
    logic [16:0] sum;
    logic [15:0] kill_score;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    logic [15:0] high_score_q, high_score_d;
`endif

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        score_d       = score_q;
        timer_d       = timer_q;
        enemy_reset_d = 1'b0;
        add_life_d    = add_life_q;
`ifdef GAME_SEQ_HIGH_SCORE_EN
        high_score_d  = high_score_q;
`endif
        award      = 17'(points_p) * 17'(level_q);
        sum        = {1'b0, score_q} + award;
        kill_score = sum[16] ? 16'hFFFF : sum[15:0];

        case (state_q)
            IDLE: begin
                if (gs.start_i) begin
                    state_d       = PLAY;
                    score_d       = 16'd0;
                    level_d       = 4'd1;
                    enemy_reset_d = 1'b1;
                end
            end
            PLAY: begin
                // kills are scored even when an exit fires in the same cycle
                if (gs.enemy_killed_i) score_d = kill_score;
                // lives counter samples only on frame ticks, so hold add_life through one
                if (gs.frame_i && add_life_q) add_life_d = 1'b0;
                if (!gs.player_alive_i) begin
                    state_d    = OVER;
                    add_life_d = 1'b0;
`ifdef GAME_SEQ_HIGH_SCORE_EN
                    if (score_d > high_score_q) high_score_d = score_d;
`endif
                end else if (gs.player_hit_i) begin
                    state_d = HIT;
                end else if (gs.all_enemies_dead_i) begin
                    state_d = CLEAR;
                    timer_d = 8'(clear_delay_p);
                end
            end
            HIT: begin
                if (gs.start_i) state_d = PLAY;
            end
            CLEAR: begin
                if (gs.frame_i) begin
                    if (timer_q <= 8'd1) begin
                        state_d       = PLAY;
                        timer_d       = 8'd0;
                        enemy_reset_d = 1'b1;
                        if (level_q != 4'(max_level_p)) begin
                            level_d = level_q + 4'd1;
                            // odd level stepping up lands on an even one
                            if (level_q[0]) add_life_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            OVER: begin
                if (gs.start_i) begin
                    state_d       = PLAY;
                    score_d       = 16'd0;
                    level_d       = 4'd1;
                    enemy_reset_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            level_q       <= 4'd1;
            score_q       <= 16'd0;
            timer_q       <= 8'd0;
            enemy_reset_q <= 1'b0;
            add_life_q    <= 1'b0;
`ifdef GAME_SEQ_HIGH_SCORE_EN
            high_score_q  <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            score_q       <= score_d;
            timer_q       <= timer_d;
            enemy_reset_q <= enemy_reset_d;
            add_life_q    <= add_life_d;
`ifdef GAME_SEQ_HIGH_SCORE_EN
            high_score_q  <= high_score_d;
`endif
        end
    end

    assign gs.freeze_o      = (state_q != PLAY);
    assign gs.game_frame_o  = gs.frame_i & (state_q == PLAY);
    assign gs.enemy_reset_o = enemy_reset_q;
    assign gs.add_life_o    = add_life_q;
    assign gs.level_o       = level_q;
    assign gs.score_o       = score_q;
    assign gs.state_o       = state_q;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    assign gs.high_score_o  = high_score_q;
`else
    assign gs.high_score_o  = 16'h0000;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed vector bench for game_sequencer with clear_delay_p=3
module tb_game_sequencer;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    localparam bit hs_en = 1'b1;
`else
    localparam bit hs_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    game_sequencer_if gs ();

    game_sequencer #(.max_level_p(8), .points_p(10), .clear_delay_p(3)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .gs      (gs.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f, s, h, a, k, d;
        int          st, lvl, sc;
        logic        er, al;
        int          hs;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   exp_hs = 0;

    function automatic vec_t mk(logic f, s, h, a, k, d, int st, lvl, sc, logic er, al, int hs);
        vec_t v;
        v.f = f; v.s = s; v.h = h; v.a = a; v.k = k; v.d = d;
        v.st = st; v.lvl = lvl; v.sc = sc; v.er = er; v.al = al; v.hs = hs;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, s, h, a, k, d);
        gs.frame_i = f; gs.start_i = s; gs.player_hit_i = h;
        gs.player_alive_i = a; gs.enemy_killed_i = k; gs.all_enemies_dead_i = d;
    endtask

    task automatic step(input logic f, s, h, a, k, d);
        drive(f, s, h, a, k, d);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int st, lvl, sc, input logic er, al);
        logic play;
        play = (st == 1);
        check({tag, ".state"}, int'(gs.state_o), st);
        check({tag, ".level"}, int'(gs.level_o), lvl);
        check({tag, ".score"}, int'(gs.score_o), sc);
        check({tag, ".enemy_reset"}, int'(gs.enemy_reset_o), int'(er));
        check({tag, ".add_life"}, int'(gs.add_life_o), int'(al));
        check({tag, ".high_score"}, int'(gs.high_score_o), exp_hs);
        check({tag, ".freeze"}, int'(gs.freeze_o), int'(!play));
        check({tag, ".game_frame"}, int'(gs.game_frame_o), int'(gs.frame_i & play));
    endtask

    initial begin
        // frame start hit alive kill dead | state level score er al hs
        vecs.push_back(mk(1,0,0,1,0,0, 0,1,0,   0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0, 1,1,0,   1,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,1,0,   0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,10,  0,0,0));
        vecs.push_back(mk(0,0,1,1,0,0, 2,1,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 2,1,10,  0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 2,1,10,  0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0, 1,1,10,  0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1, 3,1,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 3,1,10,  0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0, 3,1,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 3,1,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,2,10,  1,1,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,2,10,  0,1,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,2,10,  0,0,0));
        vecs.push_back(mk(0,0,0,1,0,1, 3,2,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 3,2,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 3,2,10,  0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,3,10,  1,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 1,3,40,  0,0,0));
        vecs.push_back(mk(1,0,0,1,1,0, 1,3,70,  0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 1,3,100, 0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 1,3,130, 0,0,0));
        vecs.push_back(mk(0,0,1,0,1,1, 4,3,160, 0,0,160));
        vecs.push_back(mk(0,1,0,1,0,0, 1,1,0,   1,0,160));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,10,  0,0,160));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,20,  0,0,160));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,30,  0,0,160));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,40,  0,0,160));
        vecs.push_back(mk(0,0,0,1,1,0, 1,1,50,  0,0,160));
        vecs.push_back(mk(0,0,0,0,1,0, 4,1,60,  0,0,160));
        vecs.push_back(mk(1,0,1,0,1,0, 4,1,60,  0,0,160));
        vecs.push_back(mk(0,1,0,1,0,0, 1,1,0,   1,0,160));
        vecs.push_back(mk(0,0,1,1,0,1, 2,1,0,   0,0,160));
        vecs.push_back(mk(0,1,0,1,0,0, 1,1,0,   0,0,160));

        drive(1, 0, 0, 1, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 1, 0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].f, vecs[i].s, vecs[i].h, vecs[i].a, vecs[i].k, vecs[i].d);
            exp_hs = hs_en ? vecs[i].hs : 0;
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].sc, vecs[i].er, vecs[i].al);
        end

        // climb to the top level, then one more clear must not go past it
        for (int l = 2; l <= 9; l++) begin
            int nl;
            nl = (l > 8) ? 8 : l;
            step(0, 0, 0, 1, 0, 1);
            expect_out($sformatf("clr%0d.enter", l), 3, nl - ((l > 8) ? 0 : 1), 0, 1'b0, 1'b0);
            step(1, 0, 0, 1, 0, 0);
            step(1, 0, 0, 1, 0, 0);
            expect_out($sformatf("clr%0d.hold", l), 3, nl - ((l > 8) ? 0 : 1), 0, 1'b0, 1'b0);
            step(1, 0, 0, 1, 0, 0);
            expect_out($sformatf("clr%0d.exit", l), 1, nl, 0, 1'b1, (l <= 8) && (l % 2 == 0));
            step(1, 0, 0, 1, 0, 0);
            expect_out($sformatf("clr%0d.after", l), 1, nl, 0, 1'b0, 1'b0);
        end

        // 819 kills at 80 points reach 65520; the next one saturates
        for (int i = 0; i < 819; i++) step(0, 0, 0, 1, 1, 0);
        expect_out("sat.before", 1, 8, 65520, 1'b0, 1'b0);
        step(0, 0, 0, 1, 1, 0);
        expect_out("sat.hit", 1, 8, 65535, 1'b0, 1'b0);
        step(1, 0, 0, 1, 1, 0);
        expect_out("sat.hold", 1, 8, 65535, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        exp_hs = hs_en ? 65535 : 0;
        expect_out("over.max", 4, 8, 65535, 1'b0, 1'b0);
        step(0, 1, 0, 1, 0, 0);
        expect_out("newgame", 1, 1, 0, 1'b1, 1'b0);

        // reset in the middle of a clear with add_life still pending
        step(0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        expect_out("rc.lvl2", 1, 2, 0, 1'b1, 1'b1);
        step(0, 0, 0, 1, 0, 1);
        expect_out("rc.clear", 3, 2, 0, 1'b0, 1'b1);
        step(1, 0, 0, 1, 0, 0);
        expect_out("rc.timer2", 3, 2, 0, 1'b0, 1'b1);
        reset = 1'b1;
        step(1, 0, 0, 1, 0, 0);
        reset = 1'b0;
        exp_hs = 0;
        expect_out("rc.reset", 0, 1, 0, 1'b0, 1'b0);
        step(1, 0, 0, 1, 1, 0);
        expect_out("rc.idle", 0, 1, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level round controller for the space invaders game.
- Sequences attract, play, hit-pause, level-clear and game-over phases.
- Gates the per-frame tick into the player, bullet and enemy datapaths, and keeps level and score.
- Generates the add-life and enemy-wave-reset pulses those datapaths consume.

Parameters:
- max_level_p, 8, highest level; level saturates here.
- points_p, 10, base points per kill; the award is points_p*level.
- clear_delay_p, 60, frames the level-clear banner is held; range 1..255.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- frame_i  input  1  one-cycle pulse per video frame
- start_i  input  1  center button pulse; start, resume or new game
- player_hit_i  input  1  player struck by an enemy bullet
- player_alive_i  input  1  player still has lives (0 = dead)
- enemy_killed_i  input  1  one-cycle pulse per enemy destroyed
- all_enemies_dead_i  input  1  wave empty (level)
- game_frame_o  output  1  frame_i & ~freeze_o; drives all game datapaths
- freeze_o  output  1  gameplay halted
- enemy_reset_o  output  1  one-cycle pulse; reload the enemy wave
- add_life_o  output  1  request to the player lives counter
- level_o  output  4  current level, 1..max_level_p
- score_o  output  16  current score
- high_score_o  output  16  best completed-game score
- state_o  output  3  state encoding for debug

Behaviour:
- States and state_o: IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4. Any other code goes to IDLE next cycle.
- Reset (takes effect 1 cycle after reset_i is sampled high, valid from any state, including mid-CLEAR):
  - state IDLE, level_o=1, score_o=0, high_score_o=0.
  - add_life_o=0, enemy_reset_o=0, clear timer=0.
  - freeze_o=1, game_frame_o=0.
- freeze_o is combinational from state: 0 only in PLAY.
- IDLE: start_i -> PLAY; clear score to 0, level to 1, pulse enemy_reset_o for 1 cycle.
- PLAY: exit priority, evaluated the same cycle:
  1. ~player_alive_i -> OVER.
  2. player_hit_i -> HIT.
  3. all_enemies_dead_i -> CLEAR; load timer with clear_delay_p.
  4. Otherwise stay in PLAY.
- Scoring:
  - On enemy_killed_i in PLAY, score += points_p*level_o, computed at 16 bits, saturating at 16'hFFFF with no wrap.
  - A kill in the same cycle as any exit condition is still scored.
  - enemy_killed_i outside PLAY is ignored.
- HIT: start_i -> PLAY. Score and level are unchanged; no enemy reset.
- CLEAR:
  - Timer decrements by 1 on each frame_i.
  - In the cycle the timer is 1 and frame_i is high: go to PLAY, level increments unless already max_level_p, pulse enemy_reset_o.
  - If the new level is even (and was actually incremented), set add_life_o.
- add_life_o:
  - Once set, held high until the first cycle with frame_i=1 while in PLAY, inclusive.
  - Cleared the cycle after that.
  - Cleared immediately on entry to OVER or on reset.
  - It is held because the lives counter samples add_life only on frame ticks.
- OVER:
  - start_i -> PLAY as a new game: score 0, level 1, pulse enemy_reset_o.
  - high_score_o handling is under Optional Feature.
- start_i is ignored in PLAY and CLEAR.
- player_hit_i and player_alive_i are ignored outside PLAY.
- All outputs are registered except freeze_o and game_frame_o.

Optional Feature:
- Macro GAME_SEQ_HIGH_SCORE_EN.
- Defined: on the PLAY->OVER transition, if score_o > high_score_o then high_score_o <= score_o. This includes the score of a kill in the same cycle. high_score_o survives new games and is cleared only by reset_i.
- Undefined: no high-score register is built; high_score_o is tied to 16'h0000.

Test Plan:
- Reset, then start_i pulse -> state_o 0->1 next cycle, enemy_reset_o high exactly 1 cycle, level_o=1, score_o=0, game_frame_o follows frame_i.
- In PLAY at level 3, 4 enemy_killed_i pulses -> score_o=120. Preload score to 65530, one kill -> score_o=16'hFFFF (saturates).
- player_hit_i with player_alive_i=1 -> HIT, freeze_o=1, game_frame_o=0 despite frame_i. start_i -> PLAY, score and level unchanged.
- all_enemies_dead_i at level 1, clear_delay_p=3 -> PLAY after 3rd frame_i, level_o=2, enemy_reset_o pulse, add_life_o held until next frame_i in PLAY. At level 8 a further clear keeps level_o=8 with no add_life_o.
- ~player_alive_i together with enemy_killed_i at score 50, level 1 -> OVER, score 60. With GAME_SEQ_HIGH_SCORE_EN high_score_o=60; without, 0. start_i -> score 0, level 1.
- reset_i asserted mid-CLEAR (timer=2) -> IDLE next cycle, add_life_o=0, level_o=1, no enemy_reset_o pulse.
